ifetch_prefetch: RTL and testbench

- Instruction prefetch stage that runs ahead of the core's decode stage.
- Issues word reads on an AXI4-lite read channel toward the QSPI flash / memory fabric and buffers returned instructions in a small FIFO.
- Presents instructions to decode with a valid/ready handshake.
- Accepts redirects (JAL, branches) from the execute stage, discarding stale in-flight and buffered fetches.

---
 rtl/ifetch_prefetch.sv | 185 ++++++++++++++++++
 tb/tb_ifetch_prefetch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch: issues AXI4-lite word reads ahead of decode and buffers responses in a DEPTH-entry FIFO.
// One cycle from R beat to instr_valid; R is never stalled, AR issue throttles on FIFO space plus outstanding reads.
module ifetch_prefetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] araddr,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic            rready,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int QW = PW + 1;
    localparam int CW = PW + 3;
    localparam logic [CW-1:0]   DEP   = CW'(DEPTH);
    localparam logic [CW-1:0]   DEP2  = CW'(2 * DEPTH);
    localparam logic [XLEN-1:0] ALIGN = ~(XLEN'(3));

    typedef enum logic {S_IDLE, S_ADDR} state_t;

    state_t          state;
    logic            ar_stale;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nx;
    logic [CW-1:0]   live, stale, fcnt;
    logic [CW-1:0]   live_nx, stale_nx, fcnt_nx;
    logic            credit_nx;

    logic [XLEN-1:0] aq [2*DEPTH];
    logic [QW-1:0]   aq_wp, aq_rp;

    logic [31:0]     f_dat [DEPTH];
    logic [XLEN-1:0] f_pc  [DEPTH];
    logic            f_flt [DEPTH];
    logic [PW-1:0]   f_wp, f_rp;

    logic ar_hs, r_hs, r_drop, f_push, f_pop;

    assign arprot = 3'b100;
    assign rready = 1'b1;

    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid;
    assign r_drop = r_hs && (stale != '0);
    assign f_push = r_hs && !r_drop && !redirect_valid;
    assign f_pop  = instr_valid && instr_ready;

    assign instr_valid = (fcnt != '0);
    assign instr       = f_dat[f_rp];
    assign instr_pc    = f_pc[f_rp];
    assign instr_fault = f_flt[f_rp];

    // Next-cycle bookkeeping; the AR issue decision is made on these post-update values.
    always_comb begin
        live_nx     = live;
        stale_nx    = stale;
        fcnt_nx     = fcnt;
        fetch_pc_nx = fetch_pc;
        if (redirect_valid) begin
            live_nx     = '0;
            stale_nx    = stale + live + CW'(ar_hs) - CW'(r_hs);
            fcnt_nx     = '0;
            fetch_pc_nx = redirect_pc & ALIGN;
        end else begin
            live_nx  = live + CW'(ar_hs && !ar_stale) - CW'(f_push);
            stale_nx = stale + CW'(ar_hs && ar_stale) - CW'(r_drop);
            fcnt_nx  = fcnt + CW'(f_push) - CW'(f_pop);
            if (ar_hs && !ar_stale) begin
                fetch_pc_nx = fetch_pc + XLEN'(4);
            end
        end
    end

    assign credit_nx = ((live_nx + fcnt_nx) < DEP) && ((live_nx + stale_nx) < DEP2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live     <= '0;
            stale    <= '0;
            fcnt     <= '0;
            fetch_pc <= RESET_PC;
        end else begin
            live     <= live_nx;
            stale    <= stale_nx;
            fcnt     <= fcnt_nx;
            fetch_pc <= fetch_pc_nx;
        end
    end

    // A redirect never retracts a pending AR; it is marked stale and its handshake feeds stale_count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            arvalid  <= 1'b0;
            araddr   <= RESET_PC;
            ar_stale <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (credit_nx) begin
                        state   <= S_ADDR;
                        arvalid <= 1'b1;
                        araddr  <= fetch_pc_nx;
                    end
                end
                S_ADDR: begin
                    if (arready) begin
                        ar_stale <= 1'b0;
                        if (credit_nx) begin
                            araddr <= fetch_pc_nx;
                        end else begin
                            state   <= S_IDLE;
                            arvalid <= 1'b0;
                        end
                    end else if (redirect_valid) begin
                        ar_stale <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    arvalid <= 1'b0;
                end
            endcase
        end
    end

    // Issue-order address queue covers live and stale reads alike, so it is never flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aq_wp <= '0;
            aq_rp <= '0;
            for (int i = 0; i < 2 * DEPTH; i++) begin
                aq[i] <= '0;
            end
        end else begin
            if (ar_hs) begin
                aq[aq_wp] <= araddr;
                aq_wp     <= aq_wp + QW'(1);
            end
            if (r_hs) begin
                aq_rp <= aq_rp + QW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_wp <= '0;
            f_rp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                f_dat[i] <= '0;
                f_pc[i]  <= '0;
                f_flt[i] <= 1'b0;
            end
        end else if (redirect_valid) begin
            f_wp <= '0;
            f_rp <= '0;
        end else begin
            if (f_push) begin
                f_dat[f_wp] <= rdata;
                f_pc[f_wp]  <= aq[aq_rp];
                f_flt[f_wp] <= (rresp != 2'b00);
                f_wp        <= f_wp + PW'(1);
            end
            if (f_pop) begin
                f_rp <= f_rp + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with a small in-order AXI4-lite read slave.
module tb_ifetch_prefetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        flt;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rlat   = 1;
    int mark   = 0;
    logic        ar_en      = 1'b1;
    logic        fault_en   = 1'b0;
    logic [31:0] fault_addr = 32'h8;

    logic [31:0] ar_log[$];
    out_t        out_log[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    ifetch_prefetch dut (
        .clk            (clk),
        .rst            (rst),
        .araddr         (araddr),
        .arprot         (arprot),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_fault    (instr_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hABCDE137;
        if (a == 32'h4) return 32'hFFDFF0EF;
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [31:0] ar_at(input int i);
        if (i < ar_log.size()) return ar_log[i];
        return 32'hDEADBEEF;
    endfunction

    function automatic out_t out_at(input int i);
        out_t e;
        e.pc  = 32'hDEADBEEF;
        e.ins = 32'hDEADBEEF;
        e.flt = 1'b1;
        if (i < out_log.size()) e = out_log[i];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ar(input int n, input string tag);
        int k = 0;
        while (ar_log.size() < n && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(ar_log.size() >= n), 32'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        ar_en          = 1'b1;
        rlat           = 1;
        repeat (2) @(negedge clk);
        ar_log.delete();
        out_log.delete();
        rst = 1'b0;
    endtask

    // Slave and monitor act just after each falling edge, after the directed steps have driven inputs.
    initial begin : env
        out_t e;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = 2'b00;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                pend_addr.delete();
                pend_due.delete();
                rvalid  = 1'b0;
                arready = 1'b0;
            end else begin
                rvalid = 1'b0;
                if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                    rvalid = 1'b1;
                    rdata  = mem_word(pend_addr[0]);
                    rresp  = (fault_en && pend_addr[0] == fault_addr) ? 2'b10 : 2'b00;
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end
                arready = ar_en;
                if (arvalid && arready) begin
                    ar_log.push_back(araddr);
                    pend_addr.push_back(araddr);
                    pend_due.push_back(cyc + rlat);
                end
                if (instr_valid && instr_ready) begin
                    e.pc  = instr_pc;
                    e.ins = instr;
                    e.flt = instr_fault;
                    out_log.push_back(e);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset values, then stall decode: exactly four reads, FIFO full.
        @(negedge clk);
        check("rst_arvalid", arvalid, 0);
        check("rst_ivalid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_ipc", instr_pc, 0);
        check("rst_ifault", instr_fault, 0);
        check("rst_rready", rready, 1);
        check("rst_arprot", arprot, 32'h4);
        rst = 1'b0;
        @(negedge clk);
        check("first_arvalid", arvalid, 1);
        check("first_araddr", araddr, 32'h0);
        repeat (12) @(negedge clk);
        check("stall_ar_count", ar_log.size(), 4);
        check("stall_ar0", ar_at(0), 32'h0);
        check("stall_ar1", ar_at(1), 32'h4);
        check("stall_ar2", ar_at(2), 32'h8);
        check("stall_ar3", ar_at(3), 32'hC);
        check("stall_arvalid", arvalid, 0);
        check("stall_ivalid", instr_valid, 1);
        check("stall_head_pc", instr_pc, 32'h0);
        check("stall_head_ins", instr, 32'hABCDE137);
        instr_ready = 1'b1;
        repeat (12) @(negedge clk);
        check("drain_pc0", out_at(0).pc, 32'h0);
        check("drain_ins0", out_at(0).ins, 32'hABCDE137);
        check("drain_flt0", out_at(0).flt, 0);
        check("drain_pc1", out_at(1).pc, 32'h4);
        check("drain_ins1", out_at(1).ins, 32'hFFDFF0EF);
        check("drain_pc2", out_at(2).pc, 32'h8);
        check("drain_pc3", out_at(3).pc, 32'hC);
        check("resume_ar4", ar_at(4), 32'h10);

        // Redirect to 0x4 with three slow reads in flight and a fourth AR pending.
        apply_reset();
        instr_ready = 1'b1;
        rlat        = 5;
        wait_ar(3, "t3_wait_ar");
        ar_en          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4;
        @(negedge clk);
        redirect_valid = 1'b0;
        ar_en          = 1'b1;
        check("t3_hold_vld", arvalid, 1);
        check("t3_hold_addr", araddr, 32'hC);
        @(negedge clk);
        check("t3_new_vld", arvalid, 1);
        check("t3_new_addr", araddr, 32'h4);
        repeat (40) @(negedge clk);
        check("t3_ar3", ar_at(3), 32'hC);
        check("t3_ar4", ar_at(4), 32'h4);
        check("t3_out0_pc", out_at(0).pc, 32'h4);
        check("t3_out0_ins", out_at(0).ins, 32'hFFDFF0EF);
        check("t3_out1_pc", out_at(1).pc, 32'h8);
        check("t3_out2_pc", out_at(2).pc, 32'hC);

        // Redirect to 0x102 while AR 0x8 is stuck without arready.
        apply_reset();
        instr_ready = 1'b1;
        wait_ar(2, "t4_wait_ar");
        ar_en = 1'b0;
        @(negedge clk);
        check("t4_pend_vld", arvalid, 1);
        check("t4_pend_addr", araddr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t4_hold_vld", arvalid, 1);
        check("t4_hold_addr", araddr, 32'h8);
        check("t4_flush", instr_valid, 0);
        mark = out_log.size();
        check("t4_pre_count", mark, 2);
        repeat (2) @(negedge clk);
        check("t4_hold2_addr", araddr, 32'h8);
        ar_en = 1'b1;
        @(negedge clk);
        check("t4_new_vld", arvalid, 1);
        check("t4_new_addr", araddr, 32'h100);
        repeat (10) @(negedge clk);
        check("t4_ar2", ar_at(2), 32'h8);
        check("t4_ar3", ar_at(3), 32'h100);
        check("t4_popped_pc", out_at(1).pc, 32'h4);
        check("t4_first_pc", out_at(mark).pc, 32'h100);
        check("t4_first_ins", out_at(mark).ins, 32'hC0DE0100);

        // SLVERR on 0x8.
        apply_reset();
        instr_ready = 1'b1;
        fault_en    = 1'b1;
        fault_addr  = 32'h8;
        repeat (15) @(negedge clk);
        check("t5_flt1", out_at(1).flt, 0);
        check("t5_pc2", out_at(2).pc, 32'h8);
        check("t5_ins2", out_at(2).ins, 32'hC0DE0008);
        check("t5_flt2", out_at(2).flt, 1);
        check("t5_pc3", out_at(3).pc, 32'hC);
        check("t5_flt3", out_at(3).flt, 0);
        fault_en = 1'b0;

        // Asynchronous reset mid-stream.
        apply_reset();
        repeat (4) @(negedge clk);
        check("t6_pre_arvalid", arvalid, 1);
        check("t6_pre_ivalid", instr_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_arvalid", arvalid, 0);
        check("t6_async_ivalid", instr_valid, 0);
        check("t6_async_instr", instr, 0);
        repeat (2) @(negedge clk);
        ar_log.delete();
        out_log.delete();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rel_arvalid", arvalid, 1);
        check("t6_rel_araddr", araddr, 32'h0);

        // Flush a full FIFO, misaligned target, address wrap.
        apply_reset();
        repeat (12) @(negedge clk);
        check("t7_full_ivalid", instr_valid, 1);
        check("t7_full_arvalid", arvalid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("t7_flush", instr_valid, 0);
        check("t7_new_vld", arvalid, 1);
        check("t7_new_addr", araddr, 32'hFFFF_FFFC);
        instr_ready = 1'b1;
        repeat (15) @(negedge clk);
        check("t7_ar4", ar_at(4), 32'hFFFF_FFFC);
        check("t7_ar5", ar_at(5), 32'h0);
        check("t7_out0_pc", out_at(0).pc, 32'hFFFF_FFFC);
        check("t7_out0_ins", out_at(0).ins, 32'hC0DEFFFC);
        check("t7_out1_pc", out_at(1).pc, 32'h0);
        check("t7_out1_ins", out_at(1).ins, 32'hABCDE137);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
